// File: rtl/seq_alu_display.sv
// Registered ALU between the switch bank and the 7-segment digits: operands are latched by strobes,
// an opcode runs on exec, and the result register drives two hex glyph decoders.
module seq_alu_display #(
  parameter int WIDTH          = 4,
  parameter bit HEX_ACTIVE_LOW = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] operand,
  input  logic [2:0]       op,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             exec,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             valid,
  output logic [1:0]       state,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT_A = 2'd1,
    S_READY = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic             carry_q, ovf_q, zero_q, valid_q;

  logic [WIDTH:0]   add_ab, sub_ab, add_rb;
  logic [WIDTH-1:0] res_d;
  logic             carry_d, ovf_d;

  // Signed overflow from the operand and result sign bits.
  function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  function automatic logic [6:0] seg_drive(input logic [6:0] lit);
    return HEX_ACTIVE_LOW ? ~lit : lit;
  endfunction

  // All arithmetic is one bit wider so bit WIDTH carries the carry/borrow.
  always_comb begin
    add_ab  = {1'b0, a_q} + {1'b0, b_q};
    sub_ab  = {1'b0, a_q} - {1'b0, b_q};
    add_rb  = {1'b0, result_q} + {1'b0, b_q};
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op)
      3'b000: begin
        res_d   = add_ab[WIDTH-1:0];
        carry_d = add_ab[WIDTH];
        ovf_d   = add_ovf(a_q[WIDTH-1], b_q[WIDTH-1], add_ab[WIDTH-1]);
      end
      3'b001: begin
        res_d   = sub_ab[WIDTH-1:0];
        carry_d = sub_ab[WIDTH];
        ovf_d   = sub_ovf(a_q[WIDTH-1], b_q[WIDTH-1], sub_ab[WIDTH-1]);
      end
      3'b010: res_d = a_q & b_q;
      3'b011: res_d = a_q | b_q;
      3'b100: res_d = a_q ^ b_q;
      3'b101: begin
        res_d   = add_rb[WIDTH-1:0];
        carry_d = add_rb[WIDTH];
        ovf_d   = add_ovf(result_q[WIDTH-1], b_q[WIDTH-1], add_rb[WIDTH-1]);
      end
      3'b110: begin
        res_d   = {a_q[WIDTH-2:0], 1'b0};
        carry_d = a_q[WIDTH-1];
      end
      default: res_d = b_q;
    endcase
  end

  // Strobe priority load_a > load_b > exec falls out of the if/else order in each state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_a) begin
            a_q     <= operand;
            state_q <= S_GOT_A;
          end
        end
        S_GOT_A: begin
          if (load_a) begin
            a_q <= operand;
          end else if (load_b) begin
            b_q     <= operand;
            state_q <= S_READY;
          end
        end
        S_READY: begin
          if (load_a) begin
            a_q <= operand;
          end else if (load_b) begin
            b_q <= operand;
          end else if (exec) begin
            result_q <= res_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= (res_d == '0);
            valid_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          if (load_a) begin
            a_q     <= operand;
            state_q <= S_GOT_A;
          end else if (load_b) begin
            b_q <= operand;
          end else if (exec) begin
            result_q <= res_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= (res_d == '0);
            valid_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign result   = result_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign valid    = valid_q;
  assign state    = state_q;

  // The upper digit exists only when the result reaches past bit 3; missing bits read as zero.
  if (WIDTH <= 4) begin : g_narrow
    assign hex0 = seg_drive(seg_glyph(4'(result_q)));
    assign hex1 = seg_drive(7'b0000000);
  end else begin : g_wide
    assign hex0 = seg_drive(seg_glyph(result_q[3:0]));
    assign hex1 = seg_drive(seg_glyph(4'(result_q[WIDTH-1:4])));
  end

endmodule

// File: doc/seq_alu_display.md
Name: seq_alu_display

Overview:
Registered, parametrised successor to the board's combinational adder/hex-display path. Operands are captured from the switch bank into registers A and B by strobes. An opcode-selected operation is executed on command and the result is held in a result register, with flags. The result drives two 7-segment digits directly, so the block plugs straight into the top level between the switch/key inputs and the LED/HEX outputs.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 2..8.
HEX_ACTIVE_LOW, 1, 1 = segment outputs active-low (board default); 0 = active-high.

Ports:
clock  in  1  system clock; all state changes on rising edge.
reset  in  1  synchronous, active-high reset.
operand  in  WIDTH  switch value captured by load_a/load_b.
op  in  3  operation select, sampled on the exec cycle.
load_a  in  1  single-cycle strobe: capture operand into A.
load_b  in  1  single-cycle strobe: capture operand into B.
exec  in  1  single-cycle strobe: execute op.
reg_a  out  WIDTH  current A register.
reg_b  out  WIDTH  current B register.
result  out  WIDTH  result register.
carry  out  1  carry-out (ADD/ACC/SHL) or borrow (SUB); 0 for other ops.
overflow  out  1  signed two's-complement overflow for ADD/SUB/ACC; 0 otherwise.
zero  out  1  result == 0.
valid  out  1  result holds at least one executed value.
state  out  2  FSM state: 0 IDLE, 1 GOT_A, 2 READY, 3 DONE.
hex0  out  7  segments {g,f,e,d,c,b,a} for result[3:0].
hex1  out  7  segments for result[7:4], zero-extended; all segments off when WIDTH <= 4.

Behaviour:
- Reset (synchronous, active-high, wins over all strobes):
  - reg_a, reg_b, result, carry, overflow, valid cleared to 0; zero = 1; state IDLE.
  - hex0 shows '0'; hex1 shows '0', or blank when WIDTH <= 4.
  - Reset asserted mid-operation discards everything the same edge.
- Strobe priority when several are asserted in one cycle: load_a > load_b > exec. Lower-priority strobes are ignored that cycle.
- IDLE:
  - load_a -> capture A, go to GOT_A.
  - load_b and exec are ignored; A must be loaded first.
- GOT_A:
  - load_a -> recapture A, stay in GOT_A.
  - load_b -> capture B, go to READY.
  - exec is ignored.
- READY:
  - load_a or load_b -> recapture that operand, stay in READY.
  - exec -> result and flags registered on the same edge, valid = 1, go to DONE.
- DONE:
  - exec -> re-execute with current A, B and result (allows ACC chaining), stay in DONE.
  - load_b -> recapture B, stay in DONE.
  - load_a -> recapture A, go to GOT_A; result, flags and valid are held.
- Latency: result, flags and hex outputs are visible the cycle after the exec edge. All outputs are registered, except hex0/hex1, which are combinational decodes of result.
- Arithmetic is computed at WIDTH+1 bits; result = low WIDTH bits. Flags are updated only on exec.
- Opcodes:
  - 000 ADD: A+B; carry = bit WIDTH.
  - 001 SUB: A-B; carry = borrow (A<B unsigned).
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 ACC: result+B.
  - 110 SHL: A<<1; carry = A[WIDTH-1].
  - 111 PASS: B.
- Wrap-around: results are modulo 2^WIDTH, with no saturation.
- Hex decode: standard 0-F glyphs; lower-case b and d. Active-low '0' = 1000000.

Test Plan:
- Reset (WIDTH=4): assert reset 1 cycle -> result=0, zero=1, valid=0, state=0, hex0=1000000, hex1=1111111.
- ADD with overflow: load_a 7, load_b 6, op=000, exec -> next cycle result=13, carry=0, overflow=1, zero=0, valid=1, state=3, hex0=0100001 ('d').
- SUB with borrow: A=3, B=5, op=001, exec -> result=14, carry=1, overflow=0.
- ACC chain: from reset, A=1, B=9, op=101; exec twice -> result 9 (carry 0), then 2 (carry 1, overflow 1); valid stays 1.
- Ordering and priority:
  - load_b (operand=5) in IDLE -> reg_b=0, state=0.
  - In READY, load_a(operand=2) together with exec -> reg_a=2, state=2, result unchanged.
  - In DONE, reset together with exec -> all reset values.
- WIDTH=8, active-low: A=0xF0, B=0x0F, op=011, exec -> result=0xFF, hex1=hex0=0001110 ('F'), carry=0.
